// File: rtl/acc_drain_arbiter.sv
// Round-robin drain arbiter: one grant covers a whole ACC_SIZE-word burst
// from a single PE. The granted PE's word is registered onto a shared
// result bus, words are counted to find the burst end, and address order
// is checked against a running expected address.

// Per-PE gate: passes the PE's word only while that PE holds the grant,
// so the shared bus can be built as a plain OR of all lanes.
module acc_drain_lane #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          sel_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);
  assign valid_o = sel_i & valid_i;
  assign addr_o  = sel_i ? addr_i : '0;
  assign data_o  = sel_i ? data_i : '0;
endmodule

module acc_drain_arbiter #(
  parameter int NUM_PE     = 4,
  parameter int ACC_ADDR_W = 4,
  parameter int ACC_SIZE   = 9,
  parameter int DATA_W     = 16,
  localparam int IDW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int CW  = (ACC_SIZE > 1) ? $clog2(ACC_SIZE) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,      // asynchronous, active low
  input  logic                         en_i,
  input  logic [NUM_PE-1:0]            req_i,
  input  logic [NUM_PE-1:0]            valid_in_i,
  input  logic [NUM_PE*ACC_ADDR_W-1:0] addr_in_i,
  input  logic [NUM_PE*DATA_W-1:0]     data_in_i,
  output logic [NUM_PE-1:0]            grant_o,
  output logic                         out_valid_o,
  output logic [ACC_ADDR_W-1:0]        out_addr_o,
  output logic [DATA_W-1:0]            out_data_o,
  output logic [IDW-1:0]               out_pe_id_o,
  output logic                         burst_done_o,
  output logic                         busy_o,
  output logic                         err_o
);
  typedef enum logic [0:0] {IDLE, BURST} state_e;

  state_e                  ps_q;
  logic [IDW-1:0]          rr_q, gid_q;
  logic [CW-1:0]           wcnt_q;
  logic [ACC_ADDR_W-1:0]   exp_q;
  logic [NUM_PE-1:0]       grant_q;
  logic                    out_valid_q, burst_done_q, err_q;
  logic [ACC_ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [IDW-1:0]          out_pe_id_q;

  logic [NUM_PE-1:0]                 lane_v;
  logic [NUM_PE-1:0][ACC_ADDR_W-1:0] lane_a;
  logic [NUM_PE-1:0][DATA_W-1:0]     lane_d;
  logic                  sel_v;
  logic [ACC_ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0]     sel_d;
  logic                  win_vld;
  logic [IDW-1:0]        win_id, scan_idx, rr_nxt;
  logic [IDW:0]          scan_sum;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    acc_drain_lane #(.AW(ACC_ADDR_W), .DW(DATA_W)) u_lane (
      .sel_i   (grant_q[g]),
      .valid_i (valid_in_i[g]),
      .addr_i  (addr_in_i[g*ACC_ADDR_W +: ACC_ADDR_W]),
      .data_i  (data_in_i[g*DATA_W +: DATA_W]),
      .valid_o (lane_v[g]),
      .addr_o  (lane_a[g]),
      .data_o  (lane_d[g])
    );
  end

  // Grant is one-hot during a burst, so OR-ing the gated lanes selects PE gid.
  always_comb begin
    sel_v = 1'b0;
    sel_a = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sel_v = sel_v | lane_v[i];
      sel_a = sel_a | lane_a[i];
      sel_d = sel_d | lane_d[i];
    end
  end

  // Round-robin pick: first requester at rr, rr+1, ... modulo NUM_PE.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      scan_sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NUM_PE)) scan_sum = scan_sum - (IDW+1)'(NUM_PE);
      scan_idx = scan_sum[IDW-1:0];
      if (!win_vld && req_i[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  assign rr_nxt = (gid_q == IDW'(NUM_PE-1)) ? '0 : gid_q + 1'b1;

  // Arbiter FSM with registered bus, burst tracking and sticky order error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ps_q         <= IDLE;
      rr_q         <= '0;
      gid_q        <= '0;
      wcnt_q       <= '0;
      exp_q        <= '0;
      grant_q      <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_pe_id_q  <= '0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (ps_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (en_i && win_vld) begin
            grant_q <= NUM_PE'(1) << win_id;
            gid_q   <= win_id;
            wcnt_q  <= '0;
            exp_q   <= '0;
            ps_q    <= BURST;
          end
        end
        BURST: begin
          out_valid_q <= sel_v;
          if (sel_v) begin
            out_addr_q  <= sel_a;
            out_data_q  <= sel_d;
            out_pe_id_q <= gid_q;
            wcnt_q      <= wcnt_q + 1'b1;
            exp_q       <= exp_q + 1'b1;
            if (sel_a != exp_q) err_q <= 1'b1;
            // Grant drops with the last word so the PE cannot re-enter send.
            if (wcnt_q == CW'(ACC_SIZE-1)) begin
              burst_done_q <= 1'b1;
              grant_q      <= '0;
              ps_q         <= IDLE;
              rr_q         <= rr_nxt;
              wcnt_q       <= '0;
            end
          end
        end
        default: ps_q <= IDLE;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign out_valid_o  = out_valid_q;
  assign out_addr_o   = out_addr_q;
  assign out_data_o   = out_data_q;
  assign out_pe_id_o  = out_pe_id_q;
  assign burst_done_o = burst_done_q;
  assign busy_o       = (ps_q == BURST);
  assign err_o        = err_q;
endmodule

// File: tb/tb_acc_drain_arbiter.sv
// Directed bench for acc_drain_arbiter: expected bus words are queued as
// they are driven and checked on the cycle the DUT should present them.
module tb_acc_drain_arbiter;
  localparam int NP = 4, AW = 4, AS = 9, DW = 16, IDW = 2;

  logic clk = 1'b0, rst = 1'b0, en = 1'b1;
  logic [NP-1:0]    req = '0, vin = '0;
  logic [NP*AW-1:0] ain = '0;
  logic [NP*DW-1:0] din = '0;
  logic [NP-1:0]    grant;
  logic             out_valid, burst_done, busy, err;
  logic [AW-1:0]    out_addr;
  logic [DW-1:0]    out_data;
  logic [IDW-1:0]   out_pe_id;

  acc_drain_arbiter #(.NUM_PE(NP), .ACC_ADDR_W(AW), .ACC_SIZE(AS), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .valid_in_i(vin),
    .addr_in_i(ain), .data_in_i(din), .grant_o(grant), .out_valid_o(out_valid),
    .out_addr_o(out_addr), .out_data_o(out_data), .out_pe_id_o(out_pe_id),
    .burst_done_o(burst_done), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    logic [IDW-1:0] id;
    logic           last;
  } exp_t;

  exp_t q[$];
  logic [AW-1:0]  hold_a;
  logic [DW-1:0]  hold_d;
  logic [IDW-1:0] hold_id;
  int tests = 0, fails = 0;

  function automatic logic [DW-1:0] dat(input int pe, input int a);
    return 16'(32'hA000 + pe * 256 + a * 17);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then compare the bus against the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_addr", 32'(out_addr), 32'(e.a));
      chk("out_data", 32'(out_data), 32'(e.d));
      chk("out_pe_id", 32'(out_pe_id), 32'(e.id));
      chk("burst_done", 32'(burst_done), 32'(e.last));
      hold_a = e.a; hold_d = e.d; hold_id = e.id;
    end else begin
      chk("burst_done_quiet", 32'(burst_done), 32'd0);
      chk("hold_addr", 32'(out_addr), 32'(hold_a));
      chk("hold_data", 32'(out_data), 32'(hold_d));
      chk("hold_pe_id", 32'(out_pe_id), 32'(hold_id));
    end
  endtask

  task automatic idle();
    vin = '0;
    cycle();
  endtask

  // Drive one word from PE pe; junk=1 also drives misleading words on other PEs.
  task automatic word(input int pe, input int a, input bit last, input bit junk);
    exp_t e;
    vin = junk ? '1 : NP'(1) << pe;
    for (int p = 0; p < NP; p++) begin
      ain[p*AW +: AW] = (p == pe) ? AW'(a) : AW'(a + 5);
      din[p*DW +: DW] = dat(p, a);
    end
    e.a = AW'(a); e.d = dat(pe, a); e.id = IDW'(pe); e.last = last;
    q.push_back(e);
    cycle();
    chk("grant_in_burst", 32'(grant), last ? 32'd0 : 32'(NP'(1) << pe));
    chk("busy_in_burst", 32'(busy), last ? 32'd0 : 32'd1);
  endtask

  task automatic burst(input int pe, input bit junk, input bit gaps);
    for (int k = 0; k < AS; k++) begin
      word(pe, k, k == AS - 1, junk);
      if (gaps && (k % 3 == 0) && k < AS - 1) begin
        idle(); chk("grant_gap", 32'(grant), 32'(NP'(1) << pe));
        idle(); chk("grant_gap", 32'(grant), 32'(NP'(1) << pe));
      end
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b0; req = '0; vin = '0; en = 1'b1;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_pe_id", 32'(out_pe_id), 32'd0);
    q.delete();
    hold_a = '0; hold_d = '0; hold_id = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    // T1: single requester PE2, back-to-back burst
    do_reset();
    req = 4'b0100;
    idle(); chk("t1_grant", 32'(grant), 32'h4);
    req = '0;
    burst(2, 1'b0, 1'b0);
    idle(); chk("t1_grant_after", 32'(grant), 32'h0);

    // T2: all requesting, round-robin order with one idle cycle between bursts
    do_reset();
    req = 4'b1111;
    idle(); chk("t2_grant_first", 32'(grant), 32'h1);
    for (int j = 0; j < 5; j++) begin
      burst(ord[j], 1'b1, 1'b0);
      if (j < 4) begin
        idle(); chk("t2_grant_next", 32'(grant), 32'(NP'(1) << ord[j+1]));
      end
    end

    // T3: rr_ptr=2 after PE1's burst; req=1010 -> PE3 then PE1
    do_reset();
    req = 4'b0010;
    idle(); chk("t3_grant_pe1", 32'(grant), 32'h2);
    burst(1, 1'b0, 1'b0);
    req = 4'b1010;
    idle(); chk("t3_grant_pe3", 32'(grant), 32'h8);
    burst(3, 1'b1, 1'b0);
    idle(); chk("t3_grant_pe1_again", 32'(grant), 32'h2);
    req = '0;
    burst(1, 1'b0, 1'b0);
    idle(); chk("t3_grant_none", 32'(grant), 32'h0);

    // T4: gapped valid pattern from PE0
    do_reset();
    req = 4'b0001;
    idle(); chk("t4_grant", 32'(grant), 32'h1);
    req = '0;
    burst(0, 1'b0, 1'b1);
    idle();
    chk("t4_err", 32'(err), 32'd0);

    // T5: address order violation 0,1,3 -> sticky err
    do_reset();
    req = 4'b0010;
    idle(); chk("t5_grant", 32'(grant), 32'h2);
    req = '0;
    word(1, 0, 1'b0, 1'b0); chk("t5_err_a0", 32'(err), 32'd0);
    word(1, 1, 1'b0, 1'b0); chk("t5_err_a1", 32'(err), 32'd0);
    word(1, 3, 1'b0, 1'b0); chk("t5_err_a3", 32'(err), 32'd1);
    for (int a = 4; a <= 9; a++) word(1, a, a == 9, 1'b0);
    idle(); idle();
    chk("t5_err_sticky", 32'(err), 32'd1);

    // T6: reset mid-burst, then fresh burst from word 0
    do_reset();
    req = 4'b0001;
    idle(); chk("t6_grant", 32'(grant), 32'h1);
    req = '0;
    word(0, 0, 1'b0, 1'b0);
    word(0, 1, 1'b0, 1'b0);
    word(0, 2, 1'b0, 1'b0);
    word(0, 7, 1'b0, 1'b0);
    chk("t6_err_before", 32'(err), 32'd1);
    chk("t6_valid_before", 32'(out_valid), 32'd1);
    do_reset();
    req = 4'b0001;
    idle(); chk("t6_grant_after", 32'(grant), 32'h1);
    req = '0;
    burst(0, 1'b0, 1'b0);

    // T7: en gates new grants only
    do_reset();
    en = 1'b0; req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      idle(); chk("t7_grant_blocked", 32'(grant), 32'h0);
      chk("t7_busy_blocked", 32'(busy), 32'd0);
    end
    en = 1'b1;
    idle(); chk("t7_grant_en", 32'(grant), 32'h1);
    en = 1'b0;
    burst(0, 1'b0, 1'b0);
    idle(); chk("t7_grant_after_en0", 32'(grant), 32'h0);
    en = 1'b1;
    idle(); chk("t7_grant_reen", 32'(grant), 32'h1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
